// File: rtl/cpu7_exu_eclhazard.sv
// cpu7_exu_eclhazard: load scoreboard, decode stall/issue and execute operand bypass selects.
//   clk, resetn             : clock, asynchronous active-low reset
//   valid_d, rs*_d, rd_d... : decode-stage instruction
//   ld_ret_vld, ld_ret_rd   : returning load data
//   flush_e                 : kill the instruction entering execute
//   rd_m/w, wen_m/w         : memory/writeback producers for bypass
//   stall_d, issue_d        : decode hold / advance
//   rs*_sel_rf/m/w          : one-hot bypass selects per execute source
//   ld_cnt, sb_err          : outstanding loads, sticky return-protocol error
module cpu7_exu_eclhazard (
  input  logic       clk,
  input  logic       resetn,
  input  logic       valid_d,
  input  logic [4:0] rs1_d,
  input  logic [4:0] rs2_d,
  input  logic       rs1_en_d,
  input  logic       rs2_en_d,
  input  logic [4:0] rd_d,
  input  logic       wen_d,
  input  logic       ld_d,
  input  logic       ld_ret_vld,
  input  logic [4:0] ld_ret_rd,
  input  logic       flush_e,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       wen_m,
  input  logic       wen_w,
  output logic       stall_d,
  output logic       issue_d,
  output logic       rs1_sel_rf,
  output logic       rs1_sel_m,
  output logic       rs1_sel_w,
  output logic       rs2_sel_rf,
  output logic       rs2_sel_m,
  output logic       rs2_sel_w,
  output logic [1:0] ld_cnt,
  output logic       sb_err
);
  logic [31:0] sb_q, sb_d, set_v, clr_v;
  logic [1:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        valid_e_q, rs1_en_e_q, rs2_en_e_q;
  logic [4:0]  rs1_e_q, rs2_e_q;
  logic        raw, waw, full, ld_issue, ret_ok;
  logic        use1_m, use1_w, use2_m, use2_w;
  // Hazards look only at the registered scoreboard, so a same-cycle return
  // still stalls and release comes one cycle later.
  always_comb begin
    raw      = (rs1_en_d && rs1_d != 5'd0 && sb_q[rs1_d]) ||
               (rs2_en_d && rs2_d != 5'd0 && sb_q[rs2_d]);
    waw      = wen_d && rd_d != 5'd0 && sb_q[rd_d];
    full     = ld_d && cnt_q == 2'd2;
    stall_d  = valid_d && (raw || waw || full);
    issue_d  = valid_d && !stall_d;
    ld_issue = issue_d && ld_d;
    ret_ok   = ld_ret_vld && ld_ret_rd != 5'd0 && sb_q[ld_ret_rd];
    set_v    = (ld_issue && wen_d && rd_d != 5'd0) ? 32'd1 << rd_d : 32'd0;
    clr_v    = ret_ok ? 32'd1 << ld_ret_rd : 32'd0;
    sb_d     = ((sb_q & ~clr_v) | set_v) & ~32'd1;
    cnt_d    = (ld_issue && !ret_ok && cnt_q != 2'd2) ? cnt_q + 2'd1 :
               (ret_ok && !ld_issue && cnt_q != 2'd0) ? cnt_q - 2'd1 : cnt_q;
    err_d    = err_q || (ld_ret_vld && !ret_ok);
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sb_q       <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      valid_e_q  <= 1'b0;
      rs1_e_q    <= '0;
      rs2_e_q    <= '0;
      rs1_en_e_q <= 1'b0;
      rs2_en_e_q <= 1'b0;
    end else begin
      sb_q      <= sb_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      valid_e_q <= issue_d && !flush_e;
      if (issue_d) begin
        rs1_e_q    <= rs1_d;
        rs2_e_q    <= rs2_d;
        rs1_en_e_q <= rs1_en_d;
        rs2_en_e_q <= rs2_en_d;
      end
    end
  end
  // Memory stage wins over writeback when both hold the same register.
  always_comb begin
    use1_m     = valid_e_q && rs1_en_e_q && rs1_e_q != 5'd0 && rs1_e_q == rd_m && wen_m;
    use1_w     = valid_e_q && rs1_en_e_q && rs1_e_q != 5'd0 && rs1_e_q == rd_w && wen_w && !use1_m;
    use2_m     = valid_e_q && rs2_en_e_q && rs2_e_q != 5'd0 && rs2_e_q == rd_m && wen_m;
    use2_w     = valid_e_q && rs2_en_e_q && rs2_e_q != 5'd0 && rs2_e_q == rd_w && wen_w && !use2_m;
    rs1_sel_m  = use1_m;
    rs1_sel_w  = use1_w;
    rs1_sel_rf = !(use1_m || use1_w);
    rs2_sel_m  = use2_m;
    rs2_sel_w  = use2_w;
    rs2_sel_rf = !(use2_m || use2_w);
  end
  assign ld_cnt = cnt_q;
  assign sb_err = err_q;
endmodule
